mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port start, input, 1 bit: one-cycle operation request, sampled on clk.
REQ-004 The block SHALL have port op, input, 3 bits: operation code; 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU, 4 = MTHI, 5 = MTLO; 6 and 7 are reserved.
REQ-005 The block SHALL have ports A and B, input, 32 bits each: operands, sampled only when start is accepted.
REQ-006 The block SHALL have port busy, output, 1 bit: an iterative operation is in progress.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse in the cycle that HI/LO first show a new mult/div result.
REQ-008 The block SHALL have ports HI and LO, output, 32 bits each: architectural HI/LO registers.

Function
REQ-009 States SHALL be IDLE and RUN.
- IDLE -> RUN on an accepted MULT/MULTU/DIV/DIVU.
- RUN -> IDLE when the iteration counter reaches 31.
REQ-010 start SHALL be accepted only when busy = 0; start while busy SHALL be ignored with no side effects.
REQ-011 busy SHALL be high from the cycle after acceptance for exactly 32 cycles; HI/LO SHALL update on the edge that ends the last busy cycle; done SHALL be high in the following cycle only.
REQ-012 MTHI/MTLO SHALL write A into HI/LO on the accepting edge, without asserting busy or done.
REQ-013 Multiply SHALL use a radix-2 shift-add algorithm; result {HI,LO} SHALL be the full 64-bit product.
- MULT: both operands two's complement.
- MULTU: both operands unsigned.
REQ-014 Divide SHALL use restoring division on magnitudes with LO = quotient and HI = remainder.
- Quotient sign = sign(A) XOR sign(B).
- Remainder sign = sign(A).
REQ-015 Divide by zero (B = 0) SHALL give LO = 32'hFFFF_FFFF and HI = A, with normal 32-cycle latency.
REQ-016 DIV of 32'h8000_0000 by 32'hFFFF_FFFF SHALL give LO = 32'h8000_0000 and HI = 0.
REQ-017 Reserved op codes SHALL be accepted as no-ops: no state change, busy and done stay 0.
REQ-018 HI/LO SHALL hold their values while busy; intermediate iteration state SHALL be held internally, never in HI/LO.
REQ-019 start in the same cycle that done is high SHALL be accepted, since busy = 0 in that cycle.

Reset
REQ-020 Asserting reset_n low SHALL immediately clear HI, LO, busy, done, the counter and the state (to IDLE), including mid-operation; the aborted result SHALL be discarded.
REQ-021 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-022 Macro MDU_FAST_MULT_EN SHALL select the multiply implementation.
- Defined: MULT/MULTU SHALL compute with a single-cycle multiplier; busy high for 1 cycle, HI/LO updated at its end, then done.
- Undefined: the 32-cycle iterative multiply of REQ-013.
- Divide behaviour SHALL be identical either way.

Structure
REQ-023 Package mdu_pkg SHALL hold:
- the op code enumeration;
- ITER_CYCLES = 32;
- the divide-by-zero quotient constant.
REQ-024 Restoring division SHALL live in sub-module mdu_div_core, with start/operand inputs, quotient/remainder outputs and a done strobe; mdu owns HI/LO, sign fix-up and the FSM.

Verification
REQ-025 MULT A=32'hFFFF_FFFE (-2), B=3 -> after 32 busy cycles HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA, done pulses once.
REQ-026 MULTU A=B=32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=32'h0000_0001.
REQ-027 DIV A=-7 (32'hFFFF_FFF9), B=2 -> LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1); DIVU A=7, B=0 -> LO=32'hFFFF_FFFF, HI=7.
REQ-028 MTHI A=32'h1234_5678 issued in cycle 5 of a running DIVU -> ignored; HI at completion equals the divide remainder.
REQ-029 reset_n pulsed low at busy cycle 10 of MULT -> HI=LO=0, busy=0 immediately; a new MTLO A=5 accepted next cycle -> LO=5.
REQ-030 With MDU_FAST_MULT_EN defined: MULTU A=6, B=7 -> busy 1 cycle, LO=42, HI=0, done the next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS-style multiply/divide unit: op codes, FSM states,
// iteration count and the divide-by-zero quotient.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int          ITER_CYCLES = 32;
    localparam int          CNT_W       = $clog2(ITER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES - 1);
    localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;

    // Magnitude of v when it is to be read as two's complement, otherwise v unchanged.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring divider, one quotient bit per clock over ITER_CYCLES cycles.
// quotient/remainder are valid only while done is high (the final iteration cycle).
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rem_q, quo_q, div_q;
    logic [32:0]      trial, diff;
    logic             fits;
    logic [31:0]      rem_nx, quo_nx;

    // Shift the next dividend bit into the partial remainder and keep the subtraction
    // only when it does not go negative. rem_q < div_q always, so 32 bits suffice.
    always_comb begin
        trial  = {rem_q, quo_q[31]};
        diff   = trial - {1'b0, div_q};
        fits   = ~diff[32];
        rem_nx = fits ? diff[31:0] : trial[31:0];
        quo_nx = {quo_q[30:0], fits};
    end

    assign quotient  = quo_nx;
    assign remainder = rem_nx;
    assign done      = active && (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active <= 1'b0;
            cnt    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            rem_q  <= '0;
            quo_q  <= dividend;
            div_q  <= divisor;
        end else if (active) begin
            rem_q  <= rem_nx;
            quo_q  <= quo_nx;
            cnt    <= cnt + 1'b1;
            if (done) active <= 1'b0;
        end
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO: iterative shift-add multiply, restoring divide.
// Define MDU_FAST_MULT_EN to replace the iterative multiply with a single-cycle one.
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    state_e           state, state_nx;
    logic [CNT_W-1:0] cnt;
    op_e              op_in, op_q;
    logic             accept, iter_op, is_mult_q, last;
    logic             neg_q, a_neg_q, b_zero_q;
    logic [31:0]      mcand_q;
    logic [63:0]      prod_q, prod_step, prod_fin, mul_res;
    logic [32:0]      sum;
    logic [31:0]      quotient, remainder, q_fix, r_fix;
    logic             div_start, div_done;

    assign op_in     = op_e'(op);
    assign accept    = start && !busy;
    assign iter_op   = (op_in == OP_MULT) || (op_in == OP_MULTU) ||
                       (op_in == OP_DIV)  || (op_in == OP_DIVU);
    assign is_mult_q = (op_q == OP_MULT) || (op_q == OP_MULTU);
    assign last      = (cnt == CNT_LAST);
    assign div_start = accept && ((op_in == OP_DIV) || (op_in == OP_DIVU));

    mdu_div_core u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (mag(A, op_in == OP_DIV)),
        .divisor   (mag(B, op_in == OP_DIV)),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (div_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && iter_op) state_nx = RUN;
            RUN:  if (last)              state_nx = IDLE;
            default:                     state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    // Radix-2 shift-add on magnitudes: multiplier sits in prod_q[31:0] and is
    // consumed LSB-first while the partial product grows into the upper half.
    always_comb begin
        sum       = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
        prod_step = {sum, prod_q[31:1]};
`ifdef MDU_FAST_MULT_EN
        prod_fin  = {32'd0, mcand_q} * {32'd0, prod_q[31:0]};
`else
        prod_fin  = prod_step;
`endif
        mul_res   = neg_q ? -prod_fin : prod_fin;
        q_fix     = b_zero_q ? DIV0_QUOT : (neg_q ? -quotient : quotient);
        r_fix     = a_neg_q ? -remainder : remainder;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            HI       <= '0;
            LO       <= '0;
            done     <= 1'b0;
            cnt      <= '0;
            op_q     <= OP_MULT;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                case (op_in)
                    OP_MTHI: HI <= A;
                    OP_MTLO: LO <= A;
                    OP_MULT, OP_MULTU: begin
                        op_q    <= op_in;
                        neg_q   <= (op_in == OP_MULT) && (A[31] ^ B[31]);
                        mcand_q <= mag(A, op_in == OP_MULT);
                        prod_q  <= {32'd0, mag(B, op_in == OP_MULT)};
`ifdef MDU_FAST_MULT_EN
                        cnt     <= CNT_LAST;
`else
                        cnt     <= '0;
`endif
                    end
                    OP_DIV, OP_DIVU: begin
                        op_q     <= op_in;
                        neg_q    <= (op_in == OP_DIV) && (A[31] ^ B[31]);
                        a_neg_q  <= (op_in == OP_DIV) && A[31];
                        b_zero_q <= (B == 32'd0);
                        cnt      <= '0;
                    end
                    default: ;
                endcase
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                if (is_mult_q) prod_q <= prod_step;
                if (is_mult_q && last) begin
                    {HI, LO} <= mul_res;
                    done     <= 1'b1;
                end else if (!is_mult_q && div_done) begin
                    HI   <= r_fix;
                    LO   <= q_fix;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu; inputs driven on the falling edge, outputs sampled there.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          errors = 0;
    int          checks = 0;

`ifdef MDU_FAST_MULT_EN
    localparam int MULT_CYC = 1;
`else
    localparam int MULT_CYC = 32;
`endif

    always #5 clk = ~clk;

    mdu dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .A       (a),
        .B       (b),
        .busy    (busy),
        .done    (done),
        .HI      (hi),
        .LO      (lo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: request is accepted on the following rising edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'hDEAD_BEEF;
    endtask

    // Count remaining busy cycles (n0 already seen) and check the done cycle.
    task automatic finish(input string tag, input int n0, input int cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n = n0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_cycles"}, 32'(n), 32'(cyc));
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input int cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(o, av, bv);
        check({tag, "_done_low"}, {31'd0, done}, 32'd0);
        finish(tag, 0, cyc, exp_hi, exp_lo);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        // First start on the first edge after reset release; later ops start in done cycles.
        reset_n = 1'b1;
        run_op("mult_neg2x3", OP_MULT, 32'hFFFF_FFFE, 32'd3, MULT_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_CYC, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_by0", OP_DIVU, 32'd7, 32'd0, 32, 32'd7, 32'hFFFF_FFFF);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'd0, 32'h8000_0000);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32, 32'd1, 32'hFFFF_FFFD);
        @(negedge clk);
        check("div_done_pulse", {31'd0, done}, 32'd0);

        issue(OP_MTHI, 32'hAAAA_5555, 32'd0);
        check("mthi_hi", hi, 32'hAAAA_5555);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_done", {31'd0, done}, 32'd0);
        issue(OP_MTLO, 32'h0F0F_0F0F, 32'd0);
        check("mtlo_lo", lo, 32'h0F0F_0F0F);
        check("mtlo_hi", hi, 32'hAAAA_5555);

        issue(OP_RSV7, 32'h0000_0000, 32'h0000_0000);
        check("rsv_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("rsv_done", {31'd0, done}, 32'd0);
        check("rsv_hi", hi, 32'hAAAA_5555);
        check("rsv_lo", lo, 32'h0F0F_0F0F);

        // MTHI during busy cycle 5 of a DIVU must be ignored.
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        issue(OP_MTHI, 32'h1234_5678, 32'd0);
        check("divu_mid_hi", hi, 32'hAAAA_5555);
        finish("divu_ignore_mthi", 5, 32, 32'd2, 32'd14);

        run_op("multu_6x7", OP_MULTU, 32'd6, 32'd7, MULT_CYC, 32'd0, 32'd42);

        // Reset in busy cycle 10 of a MULT aborts it; MTLO right after release.
        @(negedge clk);
        issue(OP_MULT, 32'd5, 32'd5);
        repeat (9) @(negedge clk);
`ifndef MDU_FAST_MULT_EN
        check("abort_busy_before", {31'd0, busy}, 32'd1);
`endif
        reset_n = 1'b0;
        #1;
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        issue(OP_MTLO, 32'd5, 32'd0);
        check("post_rst_lo", lo, 32'd5);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("post_rst_no_done", {31'd0, done}, 32'd0);
        check("post_rst_lo_hold", lo, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
